// File: rtl/sysarray_sched.sv
// ---------------------------------------------------------------------------
// sysarray_sched
//
// Operand sequencer for the NUM x NUM sysarray GEMM core. On start it reads
// klen operand columns from the weight and feature buffers and skews them
// diagonally (lane i arrives i cycles after lane 0). It drives the array's
// value/valid/end edge inputs, waits for the far-corner PE to report its
// result, then pulses done.
//
// Optional feature: define SYSSCHED_TIMEOUT_EN to add a drain watchdog that
// forces completion (with timeout=1) after 8*NUM drain cycles without the
// corner result valid. Without it, timeout is tied to 0.
//
// Ports
//   clk           rising-edge clock
//   rst           asynchronous active-low reset
//   ena           clock enable; low freezes every register
//   start, klen   job request (klen = accumulation depth), sampled in IDLE
//   busy          job in progress (cycle after acceptance through done)
//   done          one-cycle completion pulse
//   timeout       one-cycle pulse with done when the watchdog fired
//   rd_en,rd_addr buffer read strobe and k index
//   wbuf_data     weight column k, lane i at [WL*(i+1)-1:WL*i], 1-cycle latency
//   fbuf_data     feature row k, same layout and latency
//   weightvalue / featurevalue   skewed operands to the array
//   weigthvalid / featurevalid   per-lane valid
//   weigthend   / featureend     per-lane last-element flag
//   resultvalid   array result valids; only the corner bit is used
// ---------------------------------------------------------------------------
module sysarray_sched #(
    parameter int WL  = 32,
    parameter int NUM = 16,
    parameter int KW  = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ena,
    input  logic               start,
    input  logic [KW-1:0]      klen,
    output logic               busy,
    output logic               done,
    output logic               timeout,
    output logic               rd_en,
    output logic [KW-1:0]      rd_addr,
    input  logic [WL*NUM-1:0]  wbuf_data,
    input  logic [WL*NUM-1:0]  fbuf_data,
    output logic [WL*NUM-1:0]  weightvalue,
    output logic [WL*NUM-1:0]  featurevalue,
    output logic [NUM-1:0]     weigthvalid,
    output logic [NUM-1:0]     featurevalid,
    output logic [NUM-1:0]     weigthend,
    output logic [NUM-1:0]     featureend,
    input  logic [NUM*NUM-1:0] resultvalid
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_FLUSH,
        S_DRAIN,
        S_DONE
    } state_e;

    // FLUSH lasts NUM+2 cycles: counter runs 0..NUM+1.
    localparam int              FCW        = $clog2(NUM + 2);
    localparam logic [FCW-1:0]  FLUSH_LAST = FCW'(NUM + 1);

`ifdef SYSSCHED_TIMEOUT_EN
    localparam int              WDW        = $clog2(8 * NUM + 1);
    localparam logic [WDW-1:0]  WD_LAST    = WDW'(8 * NUM - 1);
    logic [WDW-1:0]             wd_q;
`endif

    state_e          state_q;
    logic [KW-1:0]   klen_q;
    logic [KW-1:0]   rd_addr_q;
    logic            rd_en_q;
    logic            busy_q;
    logic            done_q;
    logic            timeout_q;
    logic [FCW-1:0]  flush_cnt_q;

    // Buffer data is valid the cycle after rd_en; these track that slot and
    // whether it carries the last element (k = klen-1).
    logic            dv_q;
    logic            dl_q;

    logic            corner_valid;
    logic            unused_rv;

    assign corner_valid = resultvalid[NUM*NUM-1];
    assign unused_rv    = ^resultvalid[NUM*NUM-2:0];

    assign busy    = busy_q;
    assign done    = done_q;
    assign timeout = timeout_q;
    assign rd_en   = rd_en_q;
    assign rd_addr = rd_addr_q;

    // -----------------------------------------------------------------------
    // Control FSM with registered outputs
    // -----------------------------------------------------------------------
    // NOTE: all state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            klen_q      <= '0;
            rd_addr_q   <= '0;
            rd_en_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
            flush_cnt_q <= '0;
`ifdef SYSSCHED_TIMEOUT_EN
            wd_q        <= '0;
`endif
        end else if (ena) begin
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        if (klen != '0) begin
                            klen_q    <= klen;
                            rd_addr_q <= '0;
                            rd_en_q   <= 1'b1;
                            busy_q    <= 1'b1;
                            state_q   <= S_FETCH;
                        end else begin
                            // Empty job: complete immediately, never busy.
                            done_q    <= 1'b1;
                            state_q   <= S_DONE;
                        end
                    end
                end

                S_FETCH: begin
                    if (rd_addr_q == klen_q - KW'(1)) begin
                        rd_en_q     <= 1'b0;
                        rd_addr_q   <= '0;
                        flush_cnt_q <= '0;
                        state_q     <= S_FLUSH;
                    end else begin
                        rd_addr_q   <= rd_addr_q + KW'(1);
                    end
                end

                S_FLUSH: begin
                    if (flush_cnt_q == FLUSH_LAST) begin
`ifdef SYSSCHED_TIMEOUT_EN
                        wd_q    <= '0;
`endif
                        state_q <= S_DRAIN;
                    end else begin
                        flush_cnt_q <= flush_cnt_q + FCW'(1);
                    end
                end

                S_DRAIN: begin
                    // Corner valid wins over a watchdog expiring the same cycle.
                    if (corner_valid) begin
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end
`ifdef SYSSCHED_TIMEOUT_EN
                    else if (wd_q == WD_LAST) begin
                        done_q    <= 1'b1;
                        timeout_q <= 1'b1;
                        state_q   <= S_DONE;
                    end else begin
                        wd_q <= wd_q + WDW'(1);
                    end
`endif
                end

                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end

                default: state_q <= S_IDLE;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Buffer-latency stage: marks the cycle in which buffer data is valid
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dv_q <= 1'b0;
            dl_q <= 1'b0;
        end else if (ena) begin
            dv_q <= rd_en_q;
            dl_q <= rd_en_q && (rd_addr_q == klen_q - KW'(1));
        end
    end

    // -----------------------------------------------------------------------
    // Skew pipeline: stage 0 captures lane i from the buffers, stages 1..i
    // delay it so lane i trails lane 0 by i cycles. Weight and feature lanes
    // share valid/end since they are skewed identically.
    // -----------------------------------------------------------------------
    for (genvar i = 0; i < NUM; i++) begin : g_lane
        logic [WL-1:0] w_val_q [0:i];
        logic [WL-1:0] f_val_q [0:i];
        logic [i:0]    vld_q;
        logic [i:0]    end_q;

        // NOTE: the delay lines are reset explicitly, unlike a RAM, because
        // their contents drive the array edge directly and must read as
        // "invalid, value 0" straight out of reset.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                for (int j = 0; j <= i; j++) begin
                    w_val_q[j] <= '0;
                    f_val_q[j] <= '0;
                end
                vld_q <= '0;
                end_q <= '0;
            end else if (ena) begin
                vld_q[0]   <= dv_q;
                end_q[0]   <= dv_q & dl_q;
                w_val_q[0] <= dv_q ? wbuf_data[WL*i +: WL] : '0;
                f_val_q[0] <= dv_q ? fbuf_data[WL*i +: WL] : '0;
                for (int j = 1; j <= i; j++) begin
                    vld_q[j]   <= vld_q[j-1];
                    end_q[j]   <= end_q[j-1];
                    w_val_q[j] <= vld_q[j-1] ? w_val_q[j-1] : '0;
                    f_val_q[j] <= vld_q[j-1] ? f_val_q[j-1] : '0;
                end
            end
        end

        assign weightvalue[WL*i +: WL]  = w_val_q[i];
        assign featurevalue[WL*i +: WL] = f_val_q[i];
        assign weigthvalid[i]           = vld_q[i];
        assign featurevalid[i]          = vld_q[i];
        assign weigthend[i]             = end_q[i];
        assign featureend[i]            = end_q[i];
    end

endmodule

// File: tb/tb_sysarray_sched.sv
// ---------------------------------------------------------------------------
// tb_sysarray_sched
//
// Directed bench for sysarray_sched with NUM=4, WL=16, KW=8. A cycle-stepped
// buffer model returns lane data 10*i+k (weights) and 100+10*i+k (features)
// one enabled cycle after each read, and junk otherwise. Outputs are sampled
// 1 time unit after each rising edge and compared against a skew model
// indexed by the number of enabled edges since job acceptance.
// ---------------------------------------------------------------------------
module tb_sysarray_sched;

    localparam int WL   = 16;
    localparam int NUM  = 4;
    localparam int KW   = 8;
    localparam int RMAX = 64;

    logic               clk = 1'b0;
    logic               rst;
    logic               ena;
    logic               start;
    logic [KW-1:0]      klen;
    logic               busy;
    logic               done;
    logic               timeout;
    logic               rd_en;
    logic [KW-1:0]      rd_addr;
    logic [WL*NUM-1:0]  wbuf_data;
    logic [WL*NUM-1:0]  fbuf_data;
    logic [WL*NUM-1:0]  weightvalue;
    logic [WL*NUM-1:0]  featurevalue;
    logic [NUM-1:0]     weigthvalid;
    logic [NUM-1:0]     featurevalid;
    logic [NUM-1:0]     weigthend;
    logic [NUM-1:0]     featureend;
    logic [NUM*NUM-1:0] resultvalid;

    sysarray_sched #(.WL(WL), .NUM(NUM), .KW(KW)) dut (
        .clk          (clk),
        .rst          (rst),
        .ena          (ena),
        .start        (start),
        .klen         (klen),
        .busy         (busy),
        .done         (done),
        .timeout      (timeout),
        .rd_en        (rd_en),
        .rd_addr      (rd_addr),
        .wbuf_data    (wbuf_data),
        .fbuf_data    (fbuf_data),
        .weightvalue  (weightvalue),
        .featurevalue (featurevalue),
        .weigthvalid  (weigthvalid),
        .featurevalid (featurevalid),
        .weigthend    (weigthend),
        .featureend   (featureend),
        .resultvalid  (resultvalid)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Per-cycle record of DUT outputs, indexed by cycles since acceptance.
    int                rel;
    int                eff;
    int                r_eff  [RMAX];
    logic              r_rd_en[RMAX];
    logic [KW-1:0]     r_addr [RMAX];
    logic [2:0]        r_stat [RMAX];
    logic [NUM-1:0]    r_wv   [RMAX];
    logic [NUM-1:0]    r_fv   [RMAX];
    logic [NUM-1:0]    r_we   [RMAX];
    logic [NUM-1:0]    r_fe   [RMAX];
    logic [WL*NUM-1:0] r_wval [RMAX];
    logic [WL*NUM-1:0] r_fval [RMAX];

    // One clock: buffer model responds to the read seen this cycle (only if
    // the edge is enabled), then outputs are recorded.
    task automatic step();
        logic          rd_seen;
        logic [KW-1:0] a_seen;
        logic          en_seen;
        rd_seen = rd_en;
        a_seen  = rd_addr;
        en_seen = ena;
        @(posedge clk);
        #1;
        if (en_seen) begin
            for (int i = 0; i < NUM; i++) begin
                wbuf_data[WL*i +: WL] = rd_seen ? WL'(10*i + int'(a_seen)) : WL'(16'hBEEF);
                fbuf_data[WL*i +: WL] = rd_seen ? WL'(100 + 10*i + int'(a_seen)) : WL'(16'hCAFE);
            end
            eff++;
        end
        rel++;
        if (rel < RMAX) begin
            r_eff[rel]   = eff;
            r_rd_en[rel] = rd_en;
            r_addr[rel]  = rd_addr;
            r_stat[rel]  = {busy, done, timeout};
            r_wv[rel]    = weigthvalid;
            r_fv[rel]    = featurevalid;
            r_we[rel]    = weigthend;
            r_fe[rel]    = featureend;
            r_wval[rel]  = weightvalue;
            r_fval[rel]  = featurevalue;
        end
    endtask

    // Present start with klen for one cycle, then scramble klen.
    task automatic launch(input int k);
        klen  = KW'(k);
        start = 1'b1;
        rel   = 0;
        eff   = 0;
        step();
        start = 1'b0;
        klen  = 8'hFF;
    endtask

    // Skew model: lane i shows element k at effective cycle 3+k+i.
    function automatic logic [NUM-1:0] exp_vld(input int e, input int k_len);
        logic [NUM-1:0] v;
        v = '0;
        for (int i = 0; i < NUM; i++)
            v[i] = (e - 3 - i >= 0) && (e - 3 - i < k_len);
        return v;
    endfunction

    function automatic logic [NUM-1:0] exp_end(input int e, input int k_len);
        logic [NUM-1:0] v;
        v = '0;
        for (int i = 0; i < NUM; i++)
            v[i] = (k_len > 0) && (e - 3 - i == k_len - 1);
        return v;
    endfunction

    function automatic logic [WL*NUM-1:0] exp_val(input int e, input int k_len, input int base);
        logic [WL*NUM-1:0] v;
        int kk;
        v = '0;
        for (int i = 0; i < NUM; i++) begin
            kk = e - 3 - i;
            if (kk >= 0 && kk < k_len)
                v[WL*i +: WL] = WL'(base + 10*i + kk);
        end
        return v;
    endfunction

    // Run one job for nrel cycles. ena is low for cycles st_lo..st_hi, the
    // corner valid is high in cycles ca and cb, start(klen=2) is re-pulsed in
    // cycle pulse_rel. Afterwards every recorded cycle is compared.
    task automatic run_job(input int id, input int k, input int st_lo, input int st_hi,
                           input int ca, input int cb, input int pulse_rel, input int nrel,
                           input int done_rel, input int busy_last, input int tmo_rel);
        launch(k);
        while (rel < nrel) begin
            ena         = !(rel >= st_lo && rel <= st_hi);
            resultvalid = '0;
            resultvalid[NUM*NUM-1] = (rel == ca) || (rel == cb);
            start       = (rel == pulse_rel);
            if (rel == pulse_rel) klen = 8'd2;
            step();
        end
        ena         = 1'b1;
        resultvalid = '0;
        start       = 1'b0;
        for (int r = 1; r <= nrel; r++) begin
            int   e;
            logic rd_exp;
            e      = r_eff[r];
            rd_exp = (e >= 1) && (e <= k);
            check($sformatf("j%0d_rden_r%0d", id, r), 64'(r_rd_en[r]), 64'(rd_exp));
            if (rd_exp)
                check($sformatf("j%0d_addr_r%0d", id, r), 64'(r_addr[r]), 64'(e - 1));
            check($sformatf("j%0d_stat_r%0d", id, r), 64'(r_stat[r]),
                  64'({r <= busy_last, r == done_rel, r == tmo_rel}));
            check($sformatf("j%0d_wv_r%0d", id, r), 64'(r_wv[r]), 64'(exp_vld(e, k)));
            check($sformatf("j%0d_fv_r%0d", id, r), 64'(r_fv[r]), 64'(exp_vld(e, k)));
            check($sformatf("j%0d_we_r%0d", id, r), 64'(r_we[r]), 64'(exp_end(e, k)));
            check($sformatf("j%0d_fe_r%0d", id, r), 64'(r_fe[r]), 64'(exp_end(e, k)));
            check($sformatf("j%0d_wval_r%0d", id, r), 64'(r_wval[r]), 64'(exp_val(e, k, 0)));
            check($sformatf("j%0d_fval_r%0d", id, r), 64'(r_fval[r]), 64'(exp_val(e, k, 100)));
        end
    endtask

    initial begin
        logic done_seen;
        rst         = 1'b0;
        ena         = 1'b1;
        start       = 1'b0;
        klen        = '0;
        resultvalid = '0;
        wbuf_data   = '0;
        fbuf_data   = '0;
        rel         = 0;
        eff         = 0;

        // Reset state
        #2;
        check("rst_busy",  64'(busy),        64'(0));
        check("rst_done",  64'(done),        64'(0));
        check("rst_tmo",   64'(timeout),     64'(0));
        check("rst_rden",  64'(rd_en),       64'(0));
        check("rst_addr",  64'(rd_addr),     64'(0));
        check("rst_wv",    64'(weigthvalid), 64'(0));
        check("rst_wval",  64'(weightvalue), 64'(0));
        repeat (3) @(posedge clk);
        #3;
        rst = 1'b1;
        step();
        step();

        // Job 1: klen=3, corner pulse during FLUSH is ignored, real one at 12.
        run_job(1, 3, -1, -1, 8, 12, -1, 20, 13, 13, -1);
        check("tp_addr_r1", 64'(r_addr[1]), 64'(0));
        check("tp_addr_r2", 64'(r_addr[2]), 64'(1));
        check("tp_addr_r3", 64'(r_addr[3]), 64'(2));
        check("tp_l2_r5",   64'(r_wval[5][WL*2 +: WL]), 64'(20));
        check("tp_l2_r6",   64'(r_wval[6][WL*2 +: WL]), 64'(21));
        check("tp_l2_r7",   64'(r_wval[7][WL*2 +: WL]), 64'(22));
        check("tp_l2end_r6", 64'(r_we[6][2]), 64'(0));
        check("tp_l2end_r7", 64'(r_we[7][2]), 64'(1));
        step();
        step();

        // Job 2: klen=0 completes at once with no reads, valids or busy.
        run_job(2, 0, -1, -1, -1, -1, -1, 6, 1, 0, -1);
        step();

        // Job 3: klen=5, ena low in cycles 3..5, start(klen=2) pulsed at 8.
        run_job(3, 5, 3, 5, -1, 16, 8, 22, 17, 17, -1);
        step();

        // Job 4: corner never arrives.
`ifdef SYSSCHED_TIMEOUT_EN
        run_job(4, 1, -1, -1, -1, -1, -1, 44, 40, 40, 40);
`else
        launch(1);
        done_seen = 1'b0;
        repeat (1000) begin
            step();
            if (done) done_seen = 1'b1;
        end
        check("wd_busy",   64'(busy),      64'(1));
        check("wd_nodone", 64'(done_seen), 64'(0));
        check("wd_tmo",    64'(timeout),   64'(0));
        resultvalid[NUM*NUM-1] = 1'b1;
        step();
        resultvalid = '0;
        check("wd_done",   64'(done),      64'(1));
        step();
        check("wd_idle",   64'(busy),      64'(0));
`endif
        step();

        // Job 5: reset asserted mid-FLUSH aborts immediately.
        launch(3);
        while (rel < 6) step();
        check("ab_pre_vld",  64'(weigthvalid),  64'(4'b1110));
        check("ab_pre_busy", 64'(busy),         64'(1));
        rst = 1'b0;
        #1;
        check("ab_busy",  64'(busy),         64'(0));
        check("ab_done",  64'(done),         64'(0));
        check("ab_wv",    64'(weigthvalid),  64'(0));
        check("ab_fv",    64'(featurevalid), 64'(0));
        check("ab_wval",  64'(weightvalue),  64'(0));
        check("ab_fval",  64'(featurevalue), 64'(0));
        check("ab_rden",  64'(rd_en),        64'(0));
        step();
        step();
        #2;
        rst = 1'b1;
        step();

        // Job 6: normal klen=2 job after the abort.
        run_job(6, 2, -1, -1, -1, 10, -1, 14, 11, 11, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
